ktc32_top: RTL and testbench
============================

# ktc32_top

Board-level top for the Arty S7: a compact 32-bit multicycle CPU, one unified word-addressed program/data RAM and a memory-mapped 4-bit LED register. Programs are preloaded into the RAM array (hierarchical path `ram.mem`) with `$readmemh` before reset is released. The CPU executes from word address 0, and the program drives the board LEDs by storing to the LED register.

## Interface
- `MEM_WORDS`, default 4096: RAM depth in 32-bit words. Power of two; the RAM instance must be named `ram` and its array `mem` (`logic [31:0] mem [MEM_WORDS]`).
- `clk`, input, 1 bit: system clock. Everything is rising-edge.
- `reset`, input, 1 bit: one clock; reset is synchronous and active-high.
- `led`, output, 4 bits: LED register contents.

## Operation
- Instruction format (32 bits):
  - [31:28] opcode
  - [27:24] rd
  - [23:20] rs1
  - [19:16] rs2
  - [15:0] imm; simm is sign-extended to 32 bits.
- Registers: r0–r15, 32 bits each. r0 reads as 0 and writes to it are discarded. PC holds a word address.
- Opcodes:
  - 0 ADD: rd=rs1+rs2
  - 1 SUB: rd=rs1−rs2
  - 2 AND, 3 OR, 4 XOR: bitwise on rs1, rs2
  - 5 ADDI: rd=rs1+simm
  - 6 LUI: rd={imm,16'h0}
  - 7 LW: rd=M[rs1+simm]
  - 8 SW: M[rs1+simm]=rs2 (rd ignored)
  - 9 BEQ: if rs1==rs2, pc=pc+1+simm
  - A BNE: if rs1!=rs2, pc=pc+1+simm
  - B JAL: rd=pc+1, pc=rs1+simm. rd is written before the target is used, with the old rs1 value.
  - C SLL: rd=rs1<<rs2[4:0]
  - D SRL: logical, rd=rs1>>rs2[4:0]
  - E SLT: signed, rd=(rs1<rs2)?1:0
  - F HALT: PC stops advancing; the state machine stays in HALT until reset.
- Non-taken branches, and all other non-HALT instructions, advance pc to pc+1.
- Arithmetic: all arithmetic is 32-bit modulo 2^32 with no flags.
- Address map (effective address EA, word address):
  - EA[31]=0: RAM, indexed by EA[log2(MEM_WORDS)-1:0]. Upper bits are ignored, so addresses wrap.
  - EA[31]=1: LED register. SW writes led=rs2[3:0]; LW returns {28'h0, led}.
- Instruction fetch always uses PC low bits into RAM.
- RAM: single port, synchronous read with 1-cycle latency, synchronous write. RAM contents are not cleared by reset.

## Timing
- State machine: FETCH → EXEC → (MEM for LW only) → FETCH. HALT is entered from EXEC.
- FETCH: RAM address = pc; the read data is captured as the instruction at the end of the cycle.
- EXEC:
  - ALU, LUI, JAL and branch results, plus the pc update, commit on the clock edge ending EXEC.
  - SW writes RAM or LED on that same edge.
  - LW presents EA to RAM in this cycle.
- MEM (LW only): the read data is written to rd on the edge ending MEM, then pc=pc+1.
- Cost per instruction: 2 cycles for every instruction except LW, which takes 3.
- The LED output changes on the edge ending the EXEC of the SW; it is registered and glitch-free.
- Reset, sampled on a rising edge with reset=1, sets:
  - pc=0
  - r1–r15=0
  - led=4'h0
  - state=FETCH
- Reset asserted mid-instruction aborts it; a pending SW or LW in the same cycle has no effect.
- The first fetch of address 0 occurs in the first cycle with reset=0.

## Test plan
- Reset hold: reset=1 for 3 cycles, then release → led=0 throughout reset. The fetch of word 0 starts in the first low-reset cycle.
- LED store: program `LUI r1,0x8000; ADDI r2,r0,5; SW r2,0(r1); HALT` → led=4'h5 at cycle 6 after release, and it stays there.
- Loop counter: a program increments r2, stores it to the LED register, branches back with BNE, and counts to 16 before HALT. Required responses:
  - led steps 1,2,…,F,0
  - the step interval is a constant number of cycles
  - the final value 0 is held
- Memory and r0: SW 0x12345678 to RAM word 100, then LW it into r3, ADDI r0,r0,7 and LW the LED register. Required responses:
  - r3=0x12345678
  - r0 still reads 0
  - LED readback = {28'h0, led}
- ALU/shift/compare:
  - SUB 0−1 → 0xFFFFFFFF
  - SLT −1<1 → 1
  - SRL 0x80000000>>31 → 1
  - SLL with rs2=33 → shifts by 1
  - JAL → rd=pc+1
- Reset mid-run: assert reset during a loop's EXEC of SW → led=0 on the next edge, and execution restarts from word 0.

Source files
------------

// File: rtl/ktc32_top.sv
// ktc32_top: 32-bit multicycle CPU (FETCH/EXEC/MEM) with a unified word-addressed RAM
// and a memory-mapped 4-bit LED register at EA[31]=1.

module ktc32_ram #(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    logic [31:0] mem [MEM_WORDS];

    // Contents survive reset; programs are preloaded hierarchically before release.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

module ktc32_top #(
    parameter int MEM_WORDS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] led
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [3:0]  led_q, led_d;
    logic [3:0]  ld_rd_q, ld_rd_d;
    logic        ld_io_q, ld_io_d;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [3:0]         opcode, rd, rs1, rs2;
    logic [15:0]        imm;
    logic [31:0]        simm, rs1_val, rs2_val, ea, pc_inc, alu_res;
    logic signed [31:0] rs1_s, rs2_s;

    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_val;
    logic        unused_ea;

    ktc32_ram #(.MEM_WORDS(MEM_WORDS)) ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register holds the fetched instruction for the whole EXEC cycle.
    always_comb begin
        opcode  = ram_rdata[31:28];
        rd      = ram_rdata[27:24];
        rs1     = ram_rdata[23:20];
        rs2     = ram_rdata[19:16];
        imm     = ram_rdata[15:0];
        simm    = {{16{imm[15]}}, imm};
        rs1_val = (rs1 == 4'd0) ? 32'd0 : regs_q[rs1];
        rs2_val = (rs2 == 4'd0) ? 32'd0 : regs_q[rs2];
        rs1_s   = rs1_val;
        rs2_s   = rs2_val;
        ea      = rs1_val + simm;
        pc_inc  = pc_q + 32'd1;
        case (opcode)
            4'h0:    alu_res = rs1_val + rs2_val;
            4'h1:    alu_res = rs1_val - rs2_val;
            4'h2:    alu_res = rs1_val & rs2_val;
            4'h3:    alu_res = rs1_val | rs2_val;
            4'h4:    alu_res = rs1_val ^ rs2_val;
            4'h5:    alu_res = rs1_val + simm;
            4'h6:    alu_res = {imm, 16'h0000};
            4'hB:    alu_res = pc_inc;
            4'hC:    alu_res = rs1_val << rs2_val[4:0];
            4'hD:    alu_res = rs1_val >> rs2_val[4:0];
            4'hE:    alu_res = {31'd0, (rs1_s < rs2_s)};
            default: alu_res = 32'd0;
        endcase
    end

    assign unused_ea = ^ea[30:AW];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        led_d     = led_q;
        ld_rd_d   = ld_rd_q;
        ld_io_d   = ld_io_q;
        ram_addr  = pc_q[AW-1:0];
        ram_we    = 1'b0;
        ram_wdata = rs2_val;
        wr_en     = 1'b0;
        wr_idx    = rd;
        wr_val    = alu_res;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    4'h7: begin
                        ram_addr = ea[AW-1:0];
                        ld_rd_d  = rd;
                        ld_io_d  = ea[31];
                        pc_d     = pc_q;
                        state_d  = S_MEM;
                    end
                    4'h8: begin
                        if (ea[31]) begin
                            led_d = rs2_val[3:0];
                        end else begin
                            ram_addr = ea[AW-1:0];
                            ram_we   = 1'b1;
                        end
                    end
                    4'h9: if (rs1_val == rs2_val) pc_d = pc_inc + simm;
                    4'hA: if (rs1_val != rs2_val) pc_d = pc_inc + simm;
                    4'hB: begin
                        wr_en = 1'b1;
                        pc_d  = ea;
                    end
                    4'hF: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: wr_en = 1'b1;
                endcase
            end
            S_MEM: begin
                wr_en   = 1'b1;
                wr_idx  = ld_rd_q;
                wr_val  = ld_io_q ? {28'h0, led_q} : ram_rdata;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // A store caught by reset must not land in RAM.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_idx != 4'd0)) begin
            regs_d[wr_idx] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= 32'd0;
            led_q   <= 4'h0;
            ld_rd_q <= 4'd0;
            ld_io_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            led_q   <= led_d;
            ld_rd_q <= ld_rd_d;
            ld_io_q <= ld_io_d;
            regs_q  <= regs_d;
        end
    end

    assign led = led_q;
endmodule

// File: tb/tb_ktc32_top.sv
// Testbench for ktc32_top: directed programs plus random programs checked against an
// instruction-level model of the CPU.

module tb_ktc32_top;
    localparam int WORDS = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] prog [$];
    logic [31:0] m_mem [WORDS];
    logic [31:0] m_reg [16];
    logic [31:0] m_pc;
    logic [3:0]  m_led;
    int          m_cyc;

    ktc32_top #(.MEM_WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .led   (led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [31:0] w;
        w = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < WORDS; i++) begin
            dut.ram.mem[i] = 32'd0;
            m_mem[i] = 32'd0;
        end
        for (int i = 0; i < prog.size(); i++) begin
            dut.ram.mem[i] = prog[i];
            m_mem[i] = prog[i];
        end
    endtask

    // Instruction-set interpreter: architectural effect and cycle cost per instruction.
    task automatic model_run();
        logic [31:0] ins, a, b, simm, ea, npc, res;
        int op, rd, rs1, rs2;
        logic we;
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
        m_pc = 32'd0;
        m_led = 4'h0;
        m_cyc = 0;
        for (int s = 0; s < 5000; s++) begin
            ins  = m_mem[m_pc % WORDS];
            op   = int'(ins[31:28]);
            rd   = int'(ins[27:24]);
            rs1  = int'(ins[23:20]);
            rs2  = int'(ins[19:16]);
            a    = m_reg[rs1];
            b    = m_reg[rs2];
            simm = {{16{ins[15]}}, ins[15:0]};
            m_cyc += (op == 7) ? 3 : 2;
            if (op == 15) break;
            npc = m_pc + 1;
            we  = 1'b1;
            res = 32'd0;
            case (op)
                0:  res = a + b;
                1:  res = a - b;
                2:  res = a & b;
                3:  res = a | b;
                4:  res = a ^ b;
                5:  res = a + simm;
                6:  res = {ins[15:0], 16'h0000};
                7: begin
                    ea  = a + simm;
                    res = ea[31] ? {28'h0, m_led} : m_mem[ea % WORDS];
                end
                8: begin
                    we = 1'b0;
                    ea = a + simm;
                    if (ea[31]) m_led = b[3:0];
                    else m_mem[ea % WORDS] = b;
                end
                9: begin
                    we = 1'b0;
                    if (a == b) npc = m_pc + 1 + simm;
                end
                10: begin
                    we = 1'b0;
                    if (a != b) npc = m_pc + 1 + simm;
                end
                11: begin
                    res = m_pc + 1;
                    npc = a + simm;
                end
                12: res = a << b[4:0];
                13: res = a >> b[4:0];
                14: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: we = 1'b0;
            endcase
            if (we && rd != 0) m_reg[rd] = res;
            m_pc = npc;
        end
    endtask

    task automatic run_dut(input int cycles);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic build_loop();
        prog.delete();
        prog.push_back(enc(6, 1, 0, 0, 16'h8000));
        prog.push_back(enc(5, 3, 0, 0, 16));
        prog.push_back(enc(5, 2, 2, 0, 1));
        prog.push_back(enc(8, 0, 1, 2, 0));
        prog.push_back(enc(10, 0, 2, 3, -3));
        prog.push_back(enc(15, 0, 0, 0, 0));
    endtask

    task automatic test_reset_and_led_store();
        prog.delete();
        prog.push_back(enc(6, 1, 0, 0, 16'h8000));
        prog.push_back(enc(5, 2, 0, 0, 5));
        prog.push_back(enc(8, 0, 1, 2, 0));
        prog.push_back(enc(15, 0, 0, 0, 0));
        load_prog();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if (led !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: led=%h expected 0", c, led);
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_chk++;
            if (led !== ((c >= 6) ? 4'h5 : 4'h0)) begin
                n_fail++;
                $display("FAIL led_store cycle %0d: led=%h expected %h", c, led,
                         (c >= 6) ? 4'h5 : 4'h0);
            end
        end
        repeat (20) tick();
        n_chk++;
        if (led !== 4'h5) begin
            n_fail++;
            $display("FAIL led_store_hold: led=%h expected 5", led);
        end
    endtask

    task automatic test_loop_counter();
        logic [3:0] prev;
        int k, last;
        build_loop();
        load_prog();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        prev = led;
        k = 0;
        last = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (led !== prev) begin
                k++;
                n_chk++;
                if (led !== k[3:0]) begin
                    n_fail++;
                    $display("FAIL loop_step %0d: led=%h expected %h", k, led, k[3:0]);
                end
                n_chk++;
                if (k == 1 && c != 8) begin
                    n_fail++;
                    $display("FAIL loop_first_cycle: got %0d expected 8", c);
                end else if (k > 1 && (c - last) != 6) begin
                    n_fail++;
                    $display("FAIL loop_interval step %0d: got %0d expected 6", k, c - last);
                end
                last = c;
                prev = led;
            end
        end
        n_chk++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL loop_count: got %0d steps expected 16", k);
        end
        n_chk++;
        if (led !== 4'h0) begin
            n_fail++;
            $display("FAIL loop_final_hold: led=%h expected 0", led);
        end
    endtask

    task automatic test_mem_r0();
        prog.delete();
        prog.push_back(enc(6, 1, 0, 0, 16'h1234));
        prog.push_back(enc(5, 1, 1, 0, 16'h5678));
        prog.push_back(enc(8, 0, 0, 1, 100));
        prog.push_back(enc(7, 3, 0, 0, 100));
        prog.push_back(enc(5, 0, 0, 0, 7));
        prog.push_back(enc(6, 4, 0, 0, 16'h8000));
        prog.push_back(enc(5, 5, 0, 0, 16'h000A));
        prog.push_back(enc(8, 0, 4, 5, 0));
        prog.push_back(enc(7, 6, 4, 0, 0));
        prog.push_back(enc(8, 0, 0, 3, 101));
        prog.push_back(enc(8, 0, 0, 0, 102));
        prog.push_back(enc(8, 0, 0, 6, 103));
        prog.push_back(enc(15, 0, 0, 0, 0));
        load_prog();
        model_run();
        run_dut(m_cyc + 4);
        n_chk++;
        if (dut.ram.mem[101] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mem_lw_r3: got %h expected 12345678", dut.ram.mem[101]);
        end
        n_chk++;
        if (dut.ram.mem[102] !== 32'h0) begin
            n_fail++;
            $display("FAIL mem_r0: got %h expected 0", dut.ram.mem[102]);
        end
        n_chk++;
        if (dut.ram.mem[103] !== {28'h0, led} || led !== 4'hA) begin
            n_fail++;
            $display("FAIL mem_led_readback: got %h led=%h expected 0000000a", dut.ram.mem[103], led);
        end
        for (int i = 100; i < 104; i++) begin
            n_chk++;
            if (dut.ram.mem[i] !== m_mem[i]) begin
                n_fail++;
                $display("FAIL mem_model word %0d: got %h expected %h", i, dut.ram.mem[i], m_mem[i]);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] exp_v [7];
        exp_v = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'd2, 32'd15, 32'd0, 32'd0};
        prog.delete();
        prog.push_back(enc(5, 1, 0, 0, 1));
        prog.push_back(enc(5, 2, 0, 0, 16'hFFFF));
        prog.push_back(enc(1, 3, 0, 1, 0));
        prog.push_back(enc(8, 0, 0, 3, 200));
        prog.push_back(enc(14, 4, 2, 1, 0));
        prog.push_back(enc(8, 0, 0, 4, 201));
        prog.push_back(enc(6, 5, 0, 0, 16'h8000));
        prog.push_back(enc(5, 6, 0, 0, 31));
        prog.push_back(enc(13, 7, 5, 6, 0));
        prog.push_back(enc(8, 0, 0, 7, 202));
        prog.push_back(enc(5, 8, 0, 0, 33));
        prog.push_back(enc(12, 9, 1, 8, 0));
        prog.push_back(enc(8, 0, 0, 9, 203));
        prog.push_back(enc(5, 11, 0, 0, 14));
        prog.push_back(enc(11, 11, 11, 0, 2));
        prog.push_back(enc(5, 12, 0, 0, 1));
        prog.push_back(enc(8, 0, 0, 11, 204));
        prog.push_back(enc(8, 0, 0, 12, 205));
        prog.push_back(enc(9, 0, 1, 1, 1));
        prog.push_back(enc(5, 12, 0, 0, 2));
        prog.push_back(enc(8, 0, 0, 12, 206));
        prog.push_back(enc(15, 0, 0, 0, 0));
        load_prog();
        model_run();
        run_dut(m_cyc + 4);
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (dut.ram.mem[200 + i] !== exp_v[i] || m_mem[200 + i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL alu_result word %0d: got %h expected %h", 200 + i,
                         dut.ram.mem[200 + i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        build_loop();
        load_prog();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (25) tick();
        n_chk++;
        if (led !== 4'h3) begin
            n_fail++;
            $display("FAIL midrun_before: led=%h expected 3", led);
        end
        reset = 1'b1;
        tick();
        n_chk++;
        if (led !== 4'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: led=%h expected 0", led);
        end
        reset = 1'b0;
        repeat (7) tick();
        n_chk++;
        if (led !== 4'h0) begin
            n_fail++;
            $display("FAIL midrun_restart_pre: led=%h expected 0", led);
        end
        tick();
        n_chk++;
        if (led !== 4'h1) begin
            n_fail++;
            $display("FAIL midrun_restart: led=%h expected 1", led);
        end
    endtask

    task automatic test_random();
        int rops [8];
        int kind, rd, rs1, rs2;
        logic [31:0] v;
        rops = '{0, 1, 2, 3, 4, 12, 13, 14};
        for (int it = 0; it < 6; it++) begin
            prog.delete();
            for (int n = 0; n < 28; n++) begin
                kind = $urandom_range(0, 9);
                rd   = $urandom_range(0, 15);
                rs1  = $urandom_range(0, 15);
                rs2  = $urandom_range(0, 15);
                case (kind)
                    0, 1, 2, 3: prog.push_back(enc(rops[$urandom_range(0, 7)], rd, rs1, rs2, 0));
                    4: prog.push_back(enc(5, rd, rs1, 0, $urandom_range(0, 65535)));
                    5: prog.push_back(enc(6, rd, 0, 0, $urandom_range(0, 65535)));
                    6: prog.push_back(enc(8, 0, 0, rs2, 500 + $urandom_range(0, 31)));
                    7: prog.push_back(enc(7, rd, 0, 0, 500 + $urandom_range(0, 31)));
                    8: prog.push_back(enc($urandom_range(9, 10), 0, rs1, rs2, 1));
                    default: prog.push_back(enc(5, rd, 0, 0, $urandom_range(0, 40)));
                endcase
            end
            for (int r = 1; r < 16; r++) prog.push_back(enc(8, 0, 0, r, 600 + r));
            prog.push_back(enc(15, 0, 0, 0, 0));
            load_prog();
            for (int i = 500; i < 532; i++) begin
                v = $urandom;
                dut.ram.mem[i] = v;
                m_mem[i] = v;
            end
            model_run();
            run_dut(m_cyc + 4);
            for (int i = 500; i < 616; i++) begin
                if (i < 532 || i > 600) begin
                    n_chk++;
                    if (dut.ram.mem[i] !== m_mem[i]) begin
                        n_fail++;
                        $display("FAIL random iter %0d word %0d: got %h expected %h", it, i,
                                 dut.ram.mem[i], m_mem[i]);
                    end
                end
            end
            n_chk++;
            if (led !== m_led) begin
                n_fail++;
                $display("FAIL random iter %0d led: got %h expected %h", it, led, m_led);
            end
        end
    endtask

    initial begin
        test_reset_and_led_store();
        test_loop_counter();
        test_mem_r0();
        test_alu();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
